// File: rtl/fetch_unit.sv
// Instruction fetch controller: owns the fetch pointer, addresses the ROM
// every cycle and buffers returned words in a small circular prefetch queue
// that decode drains over a valid/ready handshake. Redirects flush the queue
// and restart fetch; fetch stops once the pointer leaves the ROM window.
module fetch_unit #(
   parameter int          DEPTH      = 2,
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int          IMEM_LIMIT = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [15:0]                imem_pc,
   input  logic [15:0]                imem_instr,
   input  logic                       redirect_valid,
   input  logic [15:0]                redirect_pc,
   output logic                       inst_valid,
   input  logic                       inst_ready,
   output logic [15:0]                inst_out,
   output logic [15:0]                inst_pc,
   output logic                       fetch_done,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int                CW      = $clog2(DEPTH + 1);
   localparam int                PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [15:0]       LIMIT   = 16'(IMEM_LIMIT);
   localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0]     LAST    = PW'(DEPTH - 1);
   localparam logic              RST_DONE = (RESET_PC >= LIMIT);

   logic [15:0]   fpc_q, fpc_d;
   logic          done_q, done_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic          pop, push;
   logic [15:0]   aligned_target;
   logic [15:0]   fpc_inc;

   logic [15:0]   slot_pc    [DEPTH];
   logic [15:0]   slot_instr [DEPTH];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign aligned_target = {redirect_pc[15:1], 1'b0};
   assign fpc_inc        = fpc_q + 16'd2;

   // Handshake decode and next-state for pointer, queue bookkeeping and done flag.
   always_comb begin
      pop      = (count_q != '0) & inst_ready;
      push     = ~done_q & ((count_q < DEPTH_C) | pop) & ~redirect_valid;
      fpc_d    = fpc_q;
      done_d   = done_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (redirect_valid) begin
         // Flush wins over any pop/push; the target may already be out of range.
         fpc_d    = aligned_target;
         done_d   = (aligned_target >= LIMIT);
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            fpc_d    = fpc_inc;
            done_d   = (fpc_inc >= LIMIT);
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   // Control state register with immediate reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc_q    <= RESET_PC;
         done_q   <= RST_DONE;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         fpc_q    <= fpc_d;
         done_q   <= done_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic [15:0] pc_q;
         logic [15:0] instr_q;
         // Capture {fpc, ROM word} into this slot when it is the write target.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pc_q    <= '0;
               instr_q <= '0;
            end else if (push && (wr_ptr_q == PW'(gi))) begin
               pc_q    <= fpc_q;
               instr_q <= imem_instr;
            end
         end
         assign slot_pc[gi]    = pc_q;
         assign slot_instr[gi] = instr_q;
      end
   endgenerate

   assign imem_pc    = fpc_q;
   assign inst_valid = (count_q != '0);
   assign inst_out   = slot_instr[rd_ptr_q];
   assign inst_pc    = slot_pc[rd_ptr_q];
   assign fetch_done = done_q;
   assign occupancy  = count_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch controller that sequences the 16-entry instruction ROM for the CPU core. It owns the fetch program counter, drives the ROM address every cycle and captures returned instructions into a small prefetch queue. The queue presents instructions to decode over a valid/ready handshake. Branch/jump redirects from execute flush the queue and restart fetch at the new target. Fetch stops cleanly once the pointer leaves the populated ROM window.

## Interface
- DEPTH, 2: prefetch queue entries (≥1).
- RESET_PC, 16'h0000: fetch pointer value at reset.
- IMEM_LIMIT, 32: first byte address outside the ROM; fetch halts at or beyond it.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_pc  out  16  byte address to ROM; equals the internal fetch pointer fpc.
- imem_instr  in  16  combinational ROM data for imem_pc.
- redirect_valid  in  1  flush-and-restart request from execute.
- redirect_pc  in  16  restart byte address; bit 0 forced to 0.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_out  out  16  head instruction.
- inst_pc  out  16  byte address of head instruction.
- fetch_done  out  1  fpc ≥ IMEM_LIMIT, no further pushes.
- occupancy  out  $clog2(DEPTH+1)  current queue entry count.

## Operation
- Registered state: fpc (16b), circular queue of DEPTH × {pc[15:0], instr[15:0]}, read/write pointers, count, done flag.
- pop = inst_valid & inst_ready.
- push = !done & (count < DEPTH | pop) & !redirect_valid. On push, enqueue {fpc, imem_instr} and set fpc ← fpc + 2.
- done ← 1 when the post-push fpc ≥ IMEM_LIMIT. Comparison is unsigned on 16 bits. fpc increments mod 2^16 but never reaches wrap, because done blocks further pushes.
- Redirect has highest priority. On an edge with redirect_valid=1: count ← 0, pointers ← 0, fpc ← {redirect_pc[15:1],1'b0}, done ← (aligned target ≥ IMEM_LIMIT).
- A pop in the redirect cycle is a completed handshake. The entries are discarded regardless.
- Simultaneous push and pop at count=DEPTH: count unchanged, head advances, and the new entry is written into the freed slot.
- inst_valid = (count ≠ 0). inst_out and inst_pc come from the head entry. When count=0 they hold stale data, and consumers must ignore them.
- Instruction values are not decoded or checked. A zero word from the ROM's out-of-range path is enqueued like any other word.

## Timing
- Reset values, applied immediately on rst assertion without waiting for clk: fpc=RESET_PC, count=0, inst_valid=0, fetch_done=(RESET_PC ≥ IMEM_LIMIT), occupancy=0, imem_pc=RESET_PC. inst_out and inst_pc are 0.
- Fetch latency: the instruction at fpc is visible on inst_out one edge after it was addressed. The first inst_valid appears on the first rising edge after rst deasserts.
- Throughput: one instruction per cycle sustained when inst_ready=1.
- Redirect penalty: the edge with redirect_valid empties the queue. The target instruction becomes valid on the following edge, giving one bubble cycle.
- imem_pc changes only on clk edges or on rst assertion. It is never driven combinationally from inputs.
- Backpressure: with inst_ready=0 the queue fills in DEPTH edges. After that, fpc and imem_pc hold until a pop or redirect occurs.

## Test plan
ROM contents for all scenarios: rom[0]=16'h8080, rom[1]=16'hE101, rom[3]=16'hD067, rom[8]=16'hC07A.

- Streaming: release rst with inst_ready=1 held. inst_pc must step 0,2,4,…,30 on consecutive cycles, starting with inst_out 8080 then E101. After pc 30 is popped, fetch_done=1, inst_valid=0 and occupancy=0.
- Backpressure: inst_ready=0 from reset. After 2 edges occupancy=2, imem_pc=4, and the head stays {pc 0, 8080}. Raising inst_ready gives 8080 then E101, with no drops or duplicates.
- Redirect while full: queue full at pc 0/2, pulse redirect_valid with redirect_pc=16'h0010. The next edge gives occupancy=0 and inst_valid=0. The edge after gives inst_valid=1, inst_pc=0x10, inst_out=C07A.
- Unaligned redirect: redirect_pc=16'h0007 must fetch pc 6 with inst_out=D067.
- Out-of-range redirect: redirect_pc=16'h0040 must give fetch_done=1 and inst_valid=0 indefinitely. A later redirect_pc=0 must resume fetching with 8080.
- Async reset mid-stream: assert rst between edges while occupancy=2. inst_valid, occupancy and fetch_done must clear and imem_pc=0 within the same cycle, before any clock edge.
